// File: rtl/cla28_pipe.sv
// cla28_pipe: two-stage pipelined carry-lookahead adder with valid/ready handshake.
// Stage 1 registers per-bit propagate/generate and per-nibble group P/G.
// Stage 2 resolves group and in-group carries and registers the sum.
// Optional feature macro: CLA28_PIPE_OVF_EN adds a registered two's-complement overflow output 'ovf'.

module cla28_pipe #(
    parameter int WIDTH = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA28_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NG = WIDTH / 4;

    // The lookahead is built from whole nibbles, so other widths are rejected at elaboration.
    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8 || WIDTH > 64) begin : g_width_check
            $error("cla28_pipe: WIDTH must be a multiple of 4 in the range 8..64");
        end
    endgenerate

    // Raw per-bit propagate and generate of the incoming operands.
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] g_in;

    assign p_in = a ^ b;
    assign g_in = a & b;

    // Stage-1 registers.
    logic [WIDTH-1:0] p_q,   p_d;
    logic [WIDTH-1:0] g_q,   g_d;
    logic [NG-1:0]    p03_q, p03_d;
    logic [NG-1:0]    g03_q, g03_d;
    logic             cin_q, cin_d;
    logic             s1_valid_q, s1_valid_d;

    // Stage-2 registers.
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             out_valid_q, out_valid_d;
`ifdef CLA28_PIPE_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Pipeline advance enables.
    logic adv1;
    logic adv2;

    // Carry network of stage 2.
    logic [NG:0]      grp_carry;
    logic [WIDTH-1:0] bit_carry;
    logic [WIDTH-1:0] sum_raw;

    // Handshake: a stage moves when its successor is empty or moving; the pipe reads empty in reset.
    always_comb begin
        adv2     = !out_valid_q || out_ready;
        adv1     = !s1_valid_q || adv2;
        in_ready = adv1 || !rst_n;
    end

    // Stage 1 next state: capture operand P/G and nibble group P/G on accept, bubble when idle.
    always_comb begin
        p_d        = p_q;
        g_d        = g_q;
        p03_d      = p03_q;
        g03_d      = g03_q;
        cin_d      = cin_q;
        s1_valid_d = s1_valid_q;
        if (adv1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                p_d   = p_in;
                g_d   = g_in;
                cin_d = cin;
                for (int k = 0; k < NG; k++) begin
                    p03_d[k] = &p_in[4*k +: 4];
                    g03_d[k] = g_in[4*k+3]
                             | (p_in[4*k+3] & g_in[4*k+2])
                             | (p_in[4*k+3] & p_in[4*k+2] & g_in[4*k+1])
                             | (p_in[4*k+3] & p_in[4*k+2] & p_in[4*k+1] & g_in[4*k]);
                end
            end
        end
    end

    // Stage 2 carries: lookahead across nibbles, then short ripple inside each nibble.
    always_comb begin
        grp_carry    = '0;
        bit_carry    = '0;
        grp_carry[0] = cin_q;
        for (int k = 0; k < NG; k++) begin
            grp_carry[k+1] = g03_q[k] | (p03_q[k] & grp_carry[k]);
        end
        for (int k = 0; k < NG; k++) begin
            bit_carry[4*k] = grp_carry[k];
            for (int j = 0; j < 3; j++) begin
                bit_carry[4*k+j+1] = g_q[4*k+j] | (p_q[4*k+j] & bit_carry[4*k+j]);
            end
        end
        sum_raw = p_q ^ bit_carry;
    end

    // Stage 2 next state: load the resolved result when the output register can advance.
    always_comb begin
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
`ifdef CLA28_PIPE_OVF_EN
        ovf_d       = ovf_q;
`endif
        if (adv2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                sum_d  = sum_raw;
                cout_d = grp_carry[NG];
`ifdef CLA28_PIPE_OVF_EN
                ovf_d  = bit_carry[WIDTH-1] ^ grp_carry[NG];
`endif
            end
        end
    end

    // State registers with synchronous active-low clear of both stages.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_q         <= '0;
            g_q         <= '0;
            p03_q       <= '0;
            g03_q       <= '0;
            cin_q       <= 1'b0;
            s1_valid_q  <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef CLA28_PIPE_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            p_q         <= p_d;
            g_q         <= g_d;
            p03_q       <= p03_d;
            g03_q       <= g03_d;
            cin_q       <= cin_d;
            s1_valid_q  <= s1_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
`ifdef CLA28_PIPE_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = out_valid_q;
`ifdef CLA28_PIPE_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cla28_pipe.sv
// tb_cla28_pipe: self-checking bench for cla28_pipe (default WIDTH=28).
// Honours CLA28_PIPE_OVF_EN to also check the overflow output.

module tb_cla28_pipe;

    localparam int WIDTH = 28;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CLA28_PIPE_OVF_EN
    logic             ovf;
`endif

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } vec_t;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    exp_t q[$];
    vec_t tbl[8];

    cla28_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CLA28_PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference: plain integer addition; overflow from the operand/result sign rule.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
        logic [WIDTH:0] full;
        exp_t r;
        full   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
        r.sum  = full[WIDTH-1:0];
        r.cout = full[WIDTH];
        r.ovf  = (x[WIDTH-1] == y[WIDTH-1]) && (r.sum[WIDTH-1] != x[WIDTH-1]);
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] randOperand();
        logic [WIDTH-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '1;
            1:       v = '0;
            2:       v = {1'b0, {(WIDTH-1){1'b1}}};
            default: v = WIDTH'($urandom);
        endcase
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle of handshaked traffic checked against the scoreboard queue.
    task automatic cycleStep(input logic v, input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                             input logic ci, input logic rdy);
        @(negedge clk);
        in_valid  = v;
        a         = ai;
        b         = bi;
        cin       = ci;
        out_ready = rdy;
        #1;
        if (out_valid) begin
            if (q.size() == 0) begin
                checkOutput("unexpected out_valid", 64'(out_valid), 64'd0);
            end else begin
                checkOutput("sb sum", 64'(sum), 64'(q[0].sum));
                checkOutput("sb cout", 64'(cout), 64'(q[0].cout));
`ifdef CLA28_PIPE_OVF_EN
                checkOutput("sb ovf", 64'(ovf), 64'(q[0].ovf));
`endif
                if (out_ready) void'(q.pop_front());
            end
        end
        if (rst_n && in_valid && in_ready) q.push_back(model(a, b, cin));
    endtask

    // Single isolated beat with exact two-cycle latency check.
    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        in_valid  = 1'b1;
        a         = v.a;
        b         = v.b;
        cin       = v.cin;
        out_ready = 1'b1;
        #1;
        checkOutput($sformatf("vec%0d in_ready", idx), 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checkOutput($sformatf("vec%0d early out_valid", idx), 64'(out_valid), 64'd0);
        @(negedge clk);
        #1;
        checkOutput($sformatf("vec%0d out_valid", idx), 64'(out_valid), 64'd1);
        checkOutput($sformatf("vec%0d sum", idx), 64'(sum), 64'(v.sum));
        checkOutput($sformatf("vec%0d cout", idx), 64'(cout), 64'(v.cout));
`ifdef CLA28_PIPE_OVF_EN
        checkOutput($sformatf("vec%0d ovf", idx), 64'(ovf), 64'(v.ovf));
`endif
    endtask

    initial begin
        int k;
        logic [WIDTH-1:0] beat;

        tbl[0] = '{a: 28'h0000001, b: 28'h0000001, cin: 1'b0, sum: 28'h0000002, cout: 1'b0, ovf: 1'b0};
        tbl[1] = '{a: 28'hFFFFFFF, b: 28'h0000000, cin: 1'b1, sum: 28'h0000000, cout: 1'b1, ovf: 1'b0};
        tbl[2] = '{a: 28'hFFFFFFF, b: 28'hFFFFFFF, cin: 1'b1, sum: 28'hFFFFFFF, cout: 1'b1, ovf: 1'b0};
        tbl[3] = '{a: 28'h7FFFFFF, b: 28'h0000001, cin: 1'b0, sum: 28'h8000000, cout: 1'b0, ovf: 1'b1};
        tbl[4] = '{a: 28'hFFFFFFF, b: 28'h0000001, cin: 1'b0, sum: 28'h0000000, cout: 1'b1, ovf: 1'b0};
        tbl[5] = '{a: 28'h1234567, b: 28'h7654321, cin: 1'b0, sum: 28'h8888888, cout: 1'b0, ovf: 1'b1};
        tbl[6] = '{a: 28'hAAAAAAA, b: 28'h5555555, cin: 1'b1, sum: 28'h0000000, cout: 1'b1, ovf: 1'b0};
        tbl[7] = '{a: 28'h8000000, b: 28'h8000000, cin: 1'b0, sum: 28'h0000000, cout: 1'b1, ovf: 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b0;

        // Reset: pipe reads empty, beats offered during reset are discarded.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 28'h5;
        b        = 28'h7;
        #1;
        checkOutput("reset in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        #1;
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset sum", 64'(sum), 64'd0);
        checkOutput("reset cout", 64'(cout), 64'd0);
`ifdef CLA28_PIPE_OVF_EN
        checkOutput("reset ovf", 64'(ovf), 64'd0);
`endif
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput($sformatf("post-reset discard %0d", i), 64'(out_valid), 64'd0);
            @(negedge clk);
        end

        // Directed vector table.
        for (int i = 0; i < 8; i++) applyStimulus(tbl[i], i);

        // Back-to-back 1+1, 2+2, 3+3.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid  = (i < 3);
            a         = WIDTH'(i + 1);
            b         = WIDTH'(i + 1);
            cin       = 1'b0;
            out_ready = 1'b1;
            #1;
            checkOutput($sformatf("b2b in_ready %0d", i), 64'(in_ready), 64'd1);
            if (i >= 2 && i < 5) begin
                checkOutput($sformatf("b2b out_valid %0d", i), 64'(out_valid), 64'd1);
                checkOutput($sformatf("b2b sum %0d", i), 64'(sum), 64'(2 * (i - 1)));
            end else begin
                checkOutput($sformatf("b2b idle %0d", i), 64'(out_valid), 64'd0);
            end
        end

        // Stall: out_ready low for 5 cycles with a continuous source.
        k = 0;
        for (int i = 0; i < 5; i++) begin
            beat = WIDTH'(16 * (k + 1));
            cycleStep(1'b1, beat, 28'h0000003, 1'b0, 1'b0);
            checkOutput($sformatf("stall in_ready %0d", i), 64'(in_ready), 64'(i < 2));
            checkOutput($sformatf("stall out_valid %0d", i), 64'(out_valid), 64'(i >= 2));
            if (in_valid && in_ready) k++;
        end
        for (int i = 0; i < 10; i++) begin
            beat = WIDTH'(16 * (k + 1));
            cycleStep(k < 4, beat, 28'h0000003, 1'b0, 1'b1);
            if (in_valid && in_ready) k++;
        end
        checkOutput("stall beats accepted", 64'(k), 64'd4);
        checkOutput("stall drained", 64'(q.size()), 64'd0);

        // Reset with two beats in flight.
        cycleStep(1'b1, 28'h0000111, 28'h0000222, 1'b0, 1'b1);
        cycleStep(1'b1, 28'h0000333, 28'h0000444, 1'b0, 1'b1);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 28'h0000555;
        b        = 28'h0000666;
        #1;
        checkOutput("flush in_ready during reset", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        q.delete();
        checkOutput("flush out_valid", 64'(out_valid), 64'd0);
        cycleStep(1'b1, 28'h0000A00, 28'h00000B0, 1'b1, 1'b1);
        cycleStep(1'b1, 28'h0FFFFFF, 28'h0000001, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycleStep(1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("flush drained", 64'(q.size()), 64'd0);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            cycleStep($urandom_range(0, 9) < 7, randOperand(), randOperand(),
                      1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
        end
        for (int i = 0; i < 20; i++) cycleStep(1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("random drained", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/cla28_pipe.md
CLA28_PIPE -- requirements
Module: cla28_pipe

Interface
REQ-001 SHALL have parameter: WIDTH, 28, operand width; legal values are multiples of 4 (8..64); other values SHALL fail elaboration.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operand beat present.
REQ-005 SHALL have port: in_ready  output  1  block accepts a beat this cycle.
REQ-006 SHALL have port: a  input  WIDTH  operand A.
REQ-007 SHALL have port: b  input  WIDTH  operand B.
REQ-008 SHALL have port: cin  input  1  carry-in.
REQ-009 SHALL have port: out_valid  output  1  result beat present.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port: sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
REQ-012 SHALL have port: cout  output  1  carry out of bit WIDTH-1.

Function
REQ-013 SHALL be a 2-stage pipeline; transfer occurs on valid && ready at a clock edge.
REQ-014 Stage 1 SHALL register per-bit P=a^b, G=a&b, per-4-bit-group P03 (AND of group P) and G03 (G3|P3G2|P3P2G1|P3P2P1G0), cin, and s1_valid.
REQ-015 Stage 2 SHALL compute group carries by lookahead: c[0]=cin, c[k+1]=G03[k]|(P03[k]&c[k]); in-group carries from registered P/G; sum=P^carry; register sum, cout, out_valid.
REQ-016 Latency SHALL be exactly 2 cycles from accepted input to out_valid with no backpressure; throughput 1 beat/cycle.
REQ-017 Advance rules: adv2 = !out_valid | out_ready; adv1 = !s1_valid | adv2; in_ready = adv1 (combinational, no dependency on in_valid).
REQ-018 When adv2=0, sum/cout/out_valid and all stage-1 registers SHALL hold; no beat dropped or duplicated.
REQ-019 When adv1=1 and in_valid=0, s1_valid SHALL clear (bubble); bubbles SHALL propagate and never raise out_valid.
REQ-020 Simultaneous output consume and input accept in the same cycle SHALL both take effect (full throughput while out_ready=1).
REQ-021 Beats SHALL leave in acceptance order.
REQ-022 Overflow wrap: a=b=all-ones, cin=1 SHALL give sum=all-ones, cout=1.
REQ-023 sum/cout SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-024 With rst_n=0 at a clock edge: s1_valid=0, out_valid=0, sum=0, cout=0, stage-1 data=0.
REQ-025 During reset in_ready SHALL read 1 (pipeline empty); beats presented while rst_n=0 SHALL be discarded.
REQ-026 Reset mid-operation SHALL flush in-flight beats; first output after release SHALL be the first beat accepted after release.

Configuration
REQ-027 Macro CLA28_PIPE_OVF_EN: when defined, SHALL add output port ovf (1 bit), registered with sum, = carry into MSB XOR cout (two's-complement overflow), reset 0, held under stall.
REQ-028 Without CLA28_PIPE_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 Reset then a=0x0000001, b=0x0000001, cin=0, out_ready=1 -> out_valid 2 cycles later, sum=0x0000002, cout=0.
REQ-030 a=0xFFFFFFF, b=0x0000000, cin=1 -> sum=0x0000000, cout=1 (full-width ripple through all 7 groups).
REQ-031 Back-to-back beats 1+1, 2+2, 3+3 with out_ready=1 -> sums 2,4,6 on consecutive cycles, in_ready constant 1.
REQ-032 out_ready=0 for 5 cycles with in_valid=1 -> in_ready drops after 2 beats held; output holds first sum; release -> beats drain in order, none lost.
REQ-033 rst_n=0 for one cycle with 2 beats in flight -> out_valid=0 next cycle, in-flight beats never appear.
REQ-034 With CLA28_PIPE_OVF_EN: a=0x7FFFFFF, b=0x0000001, cin=0 -> sum=0x8000000, ovf=1, cout=0; a=0xFFFFFFF, b=0x0000001 -> ovf=0, cout=1.
